// File: rtl/byte_stream_alu.sv
// Byte-stream ALU: takes opcode, operand A, operand B over valid/ready and
// returns A+B or A-B through a ripple-carry chain on a held result handshake.
module byte_stream_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_opcode,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {GET_OP, GET_A, GET_B, HOLD} state_e;

  localparam logic [WIDTH-1:0] OPC_ADD = WIDTH'(0);
  localparam logic [WIDTH-1:0] OPC_SUB = WIDTH'(1);

  state_e           state_q;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             out_op_q;
  logic             valid_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH:0]   chain_c;
  logic             in_fire_c;

  // Input side is open in every GET state and closed while reset is asserted.
  assign in_ready  = (state_q != HOLD) && !rst;
  assign in_fire_c = in_valid && in_ready;

  // Ripple-carry chain; subtraction is A + ~B with carry-in 1.
  always_comb begin
    b_eff_c    = op_q ? ~in_data : in_data;
    sum_c      = '0;
    chain_c    = '0;
    chain_c[0] = op_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_c[i]     = a_q[i] ^ b_eff_c[i] ^ chain_c[i];
      chain_c[i+1] = (a_q[i] & b_eff_c[i]) | (chain_c[i] & (a_q[i] ^ b_eff_c[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= GET_OP;
      op_q     <= 1'b0;
      a_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      out_op_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        GET_OP: begin
          if (in_fire_c) begin
            if (in_data == OPC_ADD) begin
              op_q    <= 1'b0;
              state_q <= GET_A;
            end else if (in_data == OPC_SUB) begin
              op_q    <= 1'b1;
              state_q <= GET_A;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        GET_A: begin
          if (in_fire_c) begin
            a_q     <= in_data;
            state_q <= GET_B;
          end
        end
        GET_B: begin
          if (in_fire_c) begin
            result_q <= sum_c;
            carry_q  <= chain_c[WIDTH];
            out_op_q <= op_q;
            valid_q  <= 1'b1;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= GET_OP;
          end
        end
        default: state_q <= GET_OP;
      endcase
    end
  end

  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_op     = out_op_q;
  assign out_valid  = valid_q;
  assign err_opcode = err_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_byte_stream_alu.sv
// Directed bench for byte_stream_alu: expected results are queued as operations
// are sent and checked when the DUT raises out_valid.
module tb_byte_stream_alu;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_op;
  logic             out_valid;
  logic             out_ready;
  logic             err_opcode;
  logic [CNT_W-1:0] op_count;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             op;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt  = 0;

  byte_stream_alu #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_op     (out_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_opcode (err_opcode),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Present one byte and hold it until it is accepted (bounded).
  task automatic send(input logic [WIDTH-1:0] b);
    int waited;
    in_data  = b;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("send_ready_timeout", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Send opcode/operands and queue the expected result from integer arithmetic.
  task automatic do_op(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   full;
    if (op) begin
      e.res   = WIDTH'(int'(a) - int'(b));
      e.carry = (a >= b);
    end else begin
      full    = int'(a) + int'(b);
      e.res   = WIDTH'(full);
      e.carry = (full > 255);
    end
    e.op = op;
    sb.push_back(e);
    send(WIDTH'(op));
    send(a);
    send(b);
  endtask

  // Wait for a result, compare against the queue head, then complete the handshake.
  task automatic collect(input string tag);
    exp_t e;
    int   waited;
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'(1));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'(1));
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, 32'(out_result), 32'(e.res));
      check({tag, "_carry"},  32'(out_carry),  32'(e.carry));
      check({tag, "_op"},     32'(out_op),     32'(e.op));
      check({tag, "_in_ready_hold"}, 32'(in_ready), 32'(0));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_cnt++;
      check({tag, "_valid_clr"}, 32'(out_valid), 32'(0));
      check({tag, "_count"},     32'(op_count),  32'(exp_cnt));
      check({tag, "_in_ready"},  32'(in_ready),  32'(1));
      check({tag, "_result_kept"}, 32'(out_result), 32'(e.res));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready),   32'(0));
    check("rst_result",   32'(out_result), 32'(0));
    check("rst_carry",    32'(out_carry),  32'(0));
    check("rst_op",       32'(out_op),     32'(0));
    check("rst_valid",    32'(out_valid),  32'(0));
    check("rst_err",      32'(err_opcode), 32'(0));
    check("rst_count",    32'(op_count),   32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;

    do_op(1'b0, 8'h05, 8'h03); collect("add");
    do_op(1'b1, 8'h03, 8'h05); collect("sub_borrow");
    do_op(1'b1, 8'h05, 8'h03); collect("sub_noborrow");
    do_op(1'b0, 8'hFF, 8'h01); collect("add_wrap");

    // Illegal opcode: one pulse, no result.
    send(8'h07);
    check("err_pulse", 32'(err_opcode), 32'(1));
    @(posedge clk); #1;
    check("err_clear", 32'(err_opcode), 32'(0));
    check("err_no_valid", 32'(out_valid), 32'(0));
    send(8'h09);
    send(8'h0A);
    check("err_second_pulse", 32'(err_opcode), 32'(1));
    do_op(1'b0, 8'h10, 8'h20); collect("after_err");

    // Backpressure with stray input bytes offered during HOLD.
    do_op(1'b0, 8'h40, 8'h02);
    held     = out_result;
    in_data  = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_valid",    32'(out_valid),  32'(1));
      check("bp_result",   32'(out_result), 32'(held));
      check("bp_in_ready", 32'(in_ready),   32'(0));
      check("bp_count",    32'(op_count),   32'(exp_cnt));
    end
    in_valid = 1'b0;
    collect("bp");

    // Back-to-back: out_ready already high when the result appears.
    out_ready = 1'b1;
    do_op(1'b1, 8'h80, 8'h01);
    check("b2b_valid", 32'(out_valid), 32'(1));
    check("b2b_result", 32'(out_result), 32'(8'h7F));
    void'(sb.pop_front());
    @(posedge clk); #1;
    exp_cnt++;
    out_ready = 1'b0;
    check("b2b_valid_clr", 32'(out_valid), 32'(0));
    check("b2b_count", 32'(op_count), 32'(exp_cnt));
    check("b2b_in_ready", 32'(in_ready), 32'(1));

    // Reset in the middle of an operation.
    send(8'h00);
    send(8'h11);
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    check("mid_rst_in_ready", 32'(in_ready),   32'(0));
    check("mid_rst_result",   32'(out_result), 32'(0));
    check("mid_rst_valid",    32'(out_valid),  32'(0));
    check("mid_rst_count",    32'(op_count),   32'(0));
    check("mid_rst_op",       32'(out_op),     32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(1'b0, 8'h01, 8'h02); collect("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
